// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_if
// Brief   : Serial line and byte-strobe bundle for the UART receiver.
// Revision: 1.0  initial release
// ============================================================================
interface uart_rx_if;
    logic       rxd;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    // Line driver / byte consumer side
    modport master (
        output rxd,
        input  data, data_valid, frame_err, parity_err, rx_busy
    );

    // Receiver side
    modport slave (
        input  rxd,
        output data, data_valid, frame_err, parity_err, rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : Mid-bit-sampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN).
// Revision: 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_rx_if.slave  rx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_perr, w_perr_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_dv, w_dv_nxt;
    logic             r_fe, w_fe_nxt;
    logic             r_pe, w_pe_nxt;
    logic             r_sync1, r_sync2, r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_data  <= 8'h00;
            r_dv    <= 1'b0;
            r_fe    <= 1'b0;
            r_pe    <= 1'b0;
        end else begin
            r_sync1 <= rx.rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_perr  <= w_perr_nxt;
            r_data  <= w_data_nxt;
            r_dv    <= w_dv_nxt;
            r_fe    <= w_fe_nxt;
            r_pe    <= w_pe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_perr_nxt  = r_perr;
        w_data_nxt  = r_data;
        w_dv_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;
        w_pe_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_prev && !r_sync2)
                    w_state_nxt = S_START;
            end
            S_START: begin
                // A line back high at mid-start is a glitch, not a frame
                if (r_cnt == C_HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_perr_nxt  = 1'b0;
                    w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_perr_nxt  = r_sync2 ^ (^r_shift);
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so a following start edge is caught in IDLE
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_fe_nxt    = !r_sync2;
                    w_pe_nxt    = r_perr;
                    if (r_sync2 && !r_perr) begin
                        w_data_nxt = r_shift;
                        w_dv_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rx.data       = r_data;
    assign rx.data_valid = r_dv;
    assign rx.frame_err  = r_fe;
    assign rx.parity_err = r_pe;
    assign rx.rx_busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Directed self-checking bench for uart_rx at 16 clocks per bit.
// Revision: 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Drive time to strobe: 2 synchroniser cycles + detection-to-strobe latency
    localparam int LAT = 2 + H + (FRAME_BITS - 1) * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_start;

    int         dv_cyc[$];
    logic [7:0] dv_dat[$];
    int         fe_cyc[$];
    int         pe_cyc[$];
    int         busy_cnt = 0;

    uart_rx_if rx();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx.data_valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(rx.data);
        end
        if (rx.frame_err)  fe_cyc.push_back(cyc);
        if (rx.parity_err) pe_cyc.push_back(cyc);
        if (rx.rx_busy)    busy_cnt++;
    end

    task automatic drive_bit(input logic v);
        rx.rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx.rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        last_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ bad_par);
`else
        if (bad_par) begin end
`endif
        drive_bit(stop_bit);
        rx.rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx.rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rx.data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx.data); end
        checks++; if (rx.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", rx.data_valid); end
        checks++; if (rx.frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", rx.frame_err); end
        checks++; if (rx.parity_err !== 1'b0) begin errors++; $display("FAIL reset_pe got=%b exp=0", rx.parity_err); end
        checks++; if (rx.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx.rx_busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_basic();
        int b_dv, b_fe;
        b_dv = dv_cyc.size();
        b_fe = fe_cyc.size();
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        checks++; if (dv_cyc.size() - b_dv !== 1) begin errors++; $display("FAIL basic_dv_count got=%0d exp=1", dv_cyc.size() - b_dv); end
        else begin
            checks++; if (dv_dat[b_dv] !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", dv_dat[b_dv]); end
            checks++; if (dv_cyc[b_dv] - last_start !== LAT) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", dv_cyc[b_dv] - last_start, LAT); end
        end
        checks++; if (fe_cyc.size() - b_fe !== 0) begin errors++; $display("FAIL basic_fe got=%0d exp=0", fe_cyc.size() - b_fe); end
    endtask

    task automatic test_glitch();
        int b_dv, b_fe, b_busy;
        b_dv = dv_cyc.size();
        b_fe = fe_cyc.size();
        b_busy = busy_cnt;
        rx.rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(40);
        checks++; if (busy_cnt - b_busy !== H) begin errors++; $display("FAIL glitch_busy_cycles got=%0d exp=%0d", busy_cnt - b_busy, H); end
        checks++; if (dv_cyc.size() - b_dv !== 0) begin errors++; $display("FAIL glitch_dv got=%0d exp=0", dv_cyc.size() - b_dv); end
        checks++; if (fe_cyc.size() - b_fe !== 0) begin errors++; $display("FAIL glitch_fe got=%0d exp=0", fe_cyc.size() - b_fe); end
        checks++; if (rx.data !== 8'hA5) begin errors++; $display("FAIL glitch_data got=%h exp=a5", rx.data); end
    endtask

    task automatic test_frame_err();
        int b_dv, b_fe, b_pe;
        b_dv = dv_cyc.size();
        b_fe = fe_cyc.size();
        b_pe = pe_cyc.size();
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        send_frame(8'h81, 1'b0, 1'b0);
        idle(40);
        checks++; if (dv_cyc.size() - b_dv !== 1) begin errors++; $display("FAIL ferr_dv_count got=%0d exp=1", dv_cyc.size() - b_dv); end
        else begin
            checks++; if (dv_dat[b_dv] !== 8'h3C) begin errors++; $display("FAIL ferr_first_data got=%h exp=3c", dv_dat[b_dv]); end
        end
        checks++; if (fe_cyc.size() - b_fe !== 1) begin errors++; $display("FAIL ferr_fe_count got=%0d exp=1", fe_cyc.size() - b_fe); end
        else begin
            checks++; if (fe_cyc[b_fe] - last_start !== LAT) begin errors++; $display("FAIL ferr_latency got=%0d exp=%0d", fe_cyc[b_fe] - last_start, LAT); end
        end
        checks++; if (pe_cyc.size() - b_pe !== 0) begin errors++; $display("FAIL ferr_pe got=%0d exp=0", pe_cyc.size() - b_pe); end
        checks++; if (rx.data !== 8'h3C) begin errors++; $display("FAIL ferr_data_hold got=%h exp=3c", rx.data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int b_dv;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        b_dv = dv_cyc.size();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 1'b0);
        idle(20);
        checks++; if (dv_cyc.size() - b_dv !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", dv_cyc.size() - b_dv); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (dv_dat[b_dv+i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, dv_dat[b_dv+i], exp_b[i]); end
            end
            for (int i = 0; i < 2; i++) begin
                checks++; if (dv_cyc[b_dv+i+1] - dv_cyc[b_dv+i] !== FRAME_BITS*CPB) begin errors++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, dv_cyc[b_dv+i+1] - dv_cyc[b_dv+i], FRAME_BITS*CPB); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int b_dv, b_fe, b_pe;
        b = 8'h5A;
        b_dv = dv_cyc.size();
        b_fe = fe_cyc.size();
        b_pe = pe_cyc.size();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx.rxd = b[3];
        repeat (CPB/2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (rx.rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", rx.rx_busy); end
        checks++; if (rx.data !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", rx.data); end
        idle(FRAME_BITS*CPB);
        checks++; if ((dv_cyc.size() - b_dv) + (fe_cyc.size() - b_fe) + (pe_cyc.size() - b_pe) !== 0) begin
            errors++; $display("FAIL rstmid_no_strobe got=%0d exp=0", (dv_cyc.size() - b_dv) + (fe_cyc.size() - b_fe) + (pe_cyc.size() - b_pe));
        end
        send_frame(8'h12, 1'b1, 1'b0);
        idle(20);
        checks++; if (dv_cyc.size() - b_dv !== 1) begin errors++; $display("FAIL rstmid_dv_count got=%0d exp=1", dv_cyc.size() - b_dv); end
        checks++; if (rx.data !== 8'h12) begin errors++; $display("FAIL rstmid_data_after got=%h exp=12", rx.data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int b_dv, b_pe, b_fe;
        b_dv = dv_cyc.size();
        b_pe = pe_cyc.size();
        b_fe = fe_cyc.size();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        checks++; if (dv_cyc.size() - b_dv !== 1) begin errors++; $display("FAIL par_good_dv got=%0d exp=1", dv_cyc.size() - b_dv); end
        checks++; if (rx.data !== 8'h07) begin errors++; $display("FAIL par_good_data got=%h exp=07", rx.data); end
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        checks++; if (pe_cyc.size() - b_pe !== 1) begin errors++; $display("FAIL par_bad_pe got=%0d exp=1", pe_cyc.size() - b_pe); end
        checks++; if (dv_cyc.size() - b_dv !== 1) begin errors++; $display("FAIL par_bad_dv got=%0d exp=1", dv_cyc.size() - b_dv); end
        checks++; if (fe_cyc.size() - b_fe !== 0) begin errors++; $display("FAIL par_bad_fe got=%0d exp=0", fe_cyc.size() - b_fe); end
    endtask
`endif

    initial begin
        rx.rxd = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the team's transmitter path. It deserialises an asynchronous 8N1 line (8E1 when parity is compiled in) into bytes. It oversamples the line with the system clock, samples each bit at its midpoint, and presents each received byte with a one-cycle valid strobe plus error flags. It sits between the board RX pin and the command/control logic, which consumes bytes by strobe with no backpressure.

## Interface
- CLKS_PER_BIT, default 5208 (50 MHz / 9600 baud): system clocks per bit period. Must be ≥ 4.
- CLOCK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- UART_RXD  input  1  asynchronous serial line; idles high.
- DATA  output  8  last good received byte.
- DATA_VALID  output  1  one-cycle strobe; DATA is new this cycle.
- FRAME_ERR  output  1  one-cycle strobe; stop bit sampled low.
- PARITY_ERR  output  1  one-cycle strobe; parity mismatch (constant 0 without UART_RX_PARITY_EN).
- RX_BUSY  output  1  high whenever the FSM is not in IDLE.

## Operation
- UART_RXD passes through a 2-flop synchroniser initialised to 1. A third register holds the previous synchronised value for edge detection.
- H = (CLKS_PER_BIT-1)/2, using integer division. The bit-period counter is wide enough for CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: on a synchronised falling edge (previous 1, current 0), clear the counter and go to START.
  - START: after H cycles, sample the line. If 0, clear the counter and bit index, then go to DATA. If 1, the start was a glitch: return to IDLE with no strobe.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After bit index 7, go to PARITY if compiled in, otherwise go to STOP.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit and latch the mismatch. Go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit, issue the result strobe in the next cycle, and return to IDLE.
- Result strobes:
  - Stop = 1 with no parity error: DATA ← shift register, DATA_VALID = 1.
  - Stop = 0: FRAME_ERR = 1.
  - Stop = 1 with parity mismatch: PARITY_ERR = 1.
  - If both stop = 0 and parity mismatch occur, FRAME_ERR and PARITY_ERR pulse in the same cycle.
  - On any error, DATA holds its previous value and DATA_VALID stays 0.
- Strobes are mutually exclusive with DATA_VALID and never longer than one cycle.
- Returning to IDLE at mid-stop-bit is intentional. A new start is accepted only on a fresh falling edge, so a held-low (break) line produces exactly one FRAME_ERR and no further frames.
- No backpressure. A consumer that misses a DATA_VALID loses that byte.

## Timing
- Reset values: DATA = 8'h00; DATA_VALID, FRAME_ERR, PARITY_ERR, RX_BUSY = 0; FSM = IDLE; synchroniser and edge registers = 1.
- RESET asserted mid-frame abandons the frame. No strobe is produced, and the outputs are at reset values in the cycle after the RESET edge.
- Pin to synchronised value: 2 cycles.
- Edge detection (cycle E) to start sample: H cycles. Each following sample is exactly CLKS_PER_BIT cycles after the previous one.
- Edge detection to result strobe:
  - Without parity: H + 9·CLKS_PER_BIT + 1 cycles.
  - With parity: H + 10·CLKS_PER_BIT + 1 cycles.
- RX_BUSY rises the cycle after E and falls in the same cycle the result strobe is asserted.
- Back-to-back frames: a start edge arriving during the second half of the stop bit is detected normally once the FSM is in IDLE.
- Tolerates ±4% baud mismatch for CLKS_PER_BIT ≥ 16.

## Configuration
- Macro UART_RX_PARITY_EN.
- When defined: an even-parity bit is expected between D7 and the stop bit (frame 8E1). A mismatch asserts PARITY_ERR and suppresses DATA_VALID.
- When undefined: frame is 8N1, the PARITY state is absent, and PARITY_ERR is tied to 0.
- The port list is identical in both builds.

## Test plan
All scenarios use CLKS_PER_BIT = 16 (H = 7).
- Send 8N1 frame 0xA5 after reset -> DATA = 0xA5. DATA_VALID is high for exactly 1 cycle, 152 cycles after edge detection. FRAME_ERR = 0.
- Hold the line low for 4 cycles, then high -> no strobe, RX_BUSY returns to 0 after 7 cycles, DATA unchanged.
- Send 0x3C, then a frame 0x81 with the stop bit low -> first frame gives DATA = 0x3C. Second frame gives a single FRAME_ERR pulse, DATA stays 0x3C, and DATA_VALID = 0.
- Send frames 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three DATA_VALID pulses, spaced 160 cycles apart, with the correct bytes in order.
- Assert RESET for 1 cycle during D3 of frame 0x5A, then send 0x12 -> no strobe for the aborted frame, then DATA = 0x12 with DATA_VALID.
- With UART_RX_PARITY_EN defined: send 0x07 with parity 1, then 0x07 with parity 0 -> first gives DATA_VALID with DATA = 0x07. Second gives PARITY_ERR for one cycle and DATA_VALID = 0.
